// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and constants for the R-type issue controller
// Purpose: sequencer state encoding, R-type opcode/funct7 constants and the
//          4-bit ALU operation codes shared with the datapath ALU.
// Ports:   none (package).
package rv_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK
   } state_t;

   localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
   localparam logic [6:0] FUNCT7_BASE = 7'h00;
   localparam logic [6:0] FUNCT7_ALT  = 7'h20;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/rtype_alu_decode.sv
// rtl/rtype_alu_decode.sv - combinational {funct7,funct3} to ALU op decoder
// Purpose: maps the R-type function fields onto an ALU code and flags
//          combinations the ALU cannot execute.
// Ports:   funct7/funct3 in; alu_control (4b) and legal out.
module rtype_alu_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output logic [3:0] alu_control,
   output logic       legal
);

   always_comb begin
      alu_control = ALU_AND;
      legal       = 1'b0;
      if (funct7 == FUNCT7_BASE) begin
         legal = 1'b1;
         case (funct3)
            3'b000:  alu_control = ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_AND;
         endcase
      end else if (funct7 == FUNCT7_ALT) begin
         // Only ADD and SRL have an alternate (SUB / SRA) form.
         case (funct3)
            3'b000: begin
               alu_control = ALU_SUB;
               legal       = 1'b1;
            end
            3'b101: begin
               alu_control = ALU_SRA;
               legal       = 1'b1;
            end
            default: begin
               alu_control = ALU_AND;
               legal       = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rtype_issue_ctrl.sv
// rtl/rtype_issue_ctrl.sv - R-type instruction sequencer driving the regfile/ALU datapath
// Purpose: accepts RV32I words over valid/ready, steps each through
//          DECODE/EXECUTE/WRITEBACK, drives register numbers, ALU op and
//          regwrite, captures zero_flag and counts retired instructions.
// Ports:   clock, reset (async active-low); instr/instr_valid/instr_ready
//          fetch handshake; zero_flag from ALU; read_reg_num1/2, write_reg,
//          alu_control, regwrite to datapath; illegal pulse; last_zero;
//          retired count (CNT_W bits).
module rtype_issue_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic             zero_flag,
   output logic [4:0]       read_reg_num1,
   output logic [4:0]       read_reg_num2,
   output logic [4:0]       write_reg,
   output logic [3:0]       alu_control,
   output logic             regwrite,
   output logic             illegal,
   output logic             last_zero,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   logic [9:0] ir;          // {funct7, funct3} of the accepted instruction
   logic [6:0] dec_f7;
   logic [2:0] dec_f3;
   logic [3:0] dec_alu;
   logic       dec_legal;

   // Legality is judged on the incoming word at transfer so illegal can be a
   // registered pulse during DECODE; the ALU code is taken from IR afterwards.
   assign dec_f7 = (state == S_IDLE) ? instr[31:25] : ir[9:3];
   assign dec_f3 = (state == S_IDLE) ? instr[14:12] : ir[2:0];

   rtype_alu_decode u_dec (
      .funct7      (dec_f7),
      .funct3      (dec_f3),
      .alu_control (dec_alu),
      .legal       (dec_legal)
   );

   assign instr_ready = (state == S_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         ir            <= '0;
         read_reg_num1 <= '0;
         read_reg_num2 <= '0;
         write_reg     <= '0;
         alu_control   <= ALU_AND;
         regwrite      <= 1'b0;
         illegal       <= 1'b0;
         last_zero     <= 1'b0;
         retired       <= '0;
      end else begin
         regwrite <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  ir            <= {instr[31:25], instr[14:12]};
                  read_reg_num1 <= instr[19:15];
                  read_reg_num2 <= instr[24:20];
                  write_reg     <= instr[11:7];
                  illegal       <= !((instr[6:0] == OPC_RTYPE) && dec_legal);
                  state         <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (illegal) begin
                  state <= S_IDLE;
               end else begin
                  alu_control <= dec_alu;
                  state       <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               // Writes to x0 are suppressed but still retire.
               regwrite <= (write_reg != 5'd0);
               state    <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               last_zero <= zero_flag;
               retired   <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
